key_event_decoder: RTL and testbench

//  Consumer side of the debounced key line: converts the active-low debounced level
//  (1 = released) into single-cycle events for the password-lock control FSM.

---
 rtl/key_event_decoder.sv | 143 ++++++++++++++
 tb/tb_key_event_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Key event decoder: turns a debounced active-low key level into press, release,
// long-press and auto-repeat strobes, plus a held level and a press counter.
module key_event_decoder #(
    parameter int unsigned TICK_DIV   = 1000000,
    parameter int unsigned LONG_TICKS = 100,
    parameter int unsigned REP_TICKS  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dekey,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic            sync0, key_s;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic            tick_clr;
    logic [HW-1:0]   hold_cnt, hold_cnt_d;
    logic [HW-1:0]   rep_cnt, rep_cnt_d;
    logic            press_d, release_d, long_d, repeat_d, held_d;
    logic [7:0]      press_count_d;

    // Two-flop synchroniser, idles at released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0 <= 1'b1;
            key_s <= 1'b1;
        end else begin
            sync0 <= dekey;
            key_s <= sync0;
        end
    end

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    // Hold tick divider, realigned to the press edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick_clr || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= '0;
        end else begin
            state         <= state_d;
            hold_cnt      <= hold_cnt_d;
            rep_cnt       <= rep_cnt_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            repeat_pulse  <= repeat_d;
            held          <= held_d;
            press_count   <= press_count_d;
        end
    end

    // Next-state and next-output logic; release wins over a coincident tick.
    always_comb begin
        state_d       = state;
        hold_cnt_d    = hold_cnt;
        rep_cnt_d     = rep_cnt;
        press_d       = 1'b0;
        release_d     = 1'b0;
        long_d        = 1'b0;
        repeat_d      = 1'b0;
        press_count_d = press_count;
        tick_clr      = 1'b0;

        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_d       = PRESS;
                    press_d       = 1'b1;
                    press_count_d = press_count + 8'd1;
                    hold_cnt_d    = '0;
                    tick_clr      = 1'b1;
                end
            end
            PRESS: begin
                if (key_s) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (tick) begin
                    hold_cnt_d = hold_cnt + HW'(1);
                    if (hold_cnt == HW'(LONG_TICKS - 1)) begin
                        state_d   = LONG;
                        long_d    = 1'b1;
                        rep_cnt_d = '0;
                    end
                end
            end
            LONG: begin
                if (key_s) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (tick) begin
                    if (rep_cnt == HW'(REP_TICKS - 1)) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt + HW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        held_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed table, corner sequences,
// and randomized key activity against a cycle-count reference model.
module tb_key_event_decoder;

    localparam int TD = 4;
    localparam int LT = 3;
    localparam int RT = 2;

    logic       clk;
    logic       reset;
    logic       dekey;
    logic       press_pulse, release_pulse, long_pulse, repeat_pulse, held;
    logic [7:0] press_count;

    key_event_decoder #(
        .TICK_DIV  (TD),
        .LONG_TICKS(LT),
        .REP_TICKS (RT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dekey        (dekey),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: key level seen by the decoder lags dekey by two edges;
    // event timing follows from the number of edges elapsed since the press.
    bit       h0, h1;
    bit       m_pressed;
    int       m_el;
    bit [7:0] m_cnt;
    bit       ep, er, el, erp;

    int n_press, n_rel, n_long, n_rep;

    typedef struct {
        logic dk;
        int   cyc;
        logic held;
        int   cnt;
        int   np;
        int   nr;
        int   nl;
        int   nrp;
    } vec_t;

    vec_t tbl[9];

    function automatic void model_reset();
        h0 = 1'b1; h1 = 1'b1;
        m_pressed = 1'b0; m_el = 0; m_cnt = 8'd0;
        ep = 1'b0; er = 1'b0; el = 1'b0; erp = 1'b0;
    endfunction

    function automatic void model_edge(input bit d);
        bit k;
        k = h1; h1 = h0; h0 = d;
        ep = 1'b0; er = 1'b0; el = 1'b0; erp = 1'b0;
        if (!m_pressed) begin
            if (!k) begin
                m_pressed = 1'b1;
                m_el = 0;
                ep = 1'b1;
                m_cnt = m_cnt + 8'd1;
            end
        end else begin
            m_el = m_el + 1;
            if (k) begin
                m_pressed = 1'b0;
                er = 1'b1;
            end else if (m_el >= LT * TD && ((m_el - LT * TD) % (RT * TD)) == 0) begin
                if (m_el == LT * TD) el = 1'b1;
                else erp = 1'b1;
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("press_pulse", int'(press_pulse), int'(ep));
        check("release_pulse", int'(release_pulse), int'(er));
        check("long_pulse", int'(long_pulse), int'(el));
        check("repeat_pulse", int'(repeat_pulse), int'(erp));
        check("held", int'(held), int'(m_pressed));
        check("press_count", int'(press_count), int'(m_cnt));
        check("one_pulse_max",
              int'($countones({press_pulse, release_pulse, long_pulse, repeat_pulse}) <= 1), 1);
    endtask

    // One clock: update model at the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge(dekey);
        #1;
        check_all();
        n_press += int'(press_pulse);
        n_rel   += int'(release_pulse);
        n_long  += int'(long_pulse);
        n_rep   += int'(repeat_pulse);
    endtask

    task automatic clear_counts();
        n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
    endtask

    // Asynchronous reset between edges, held across one edge.
    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("async_reset_held", int'(held), 0);
        check("async_reset_long", int'(long_pulse), 0);
        check("async_reset_rep", int'(repeat_pulse), 0);
        check("async_reset_cnt", int'(press_count), 0);
        step();
        reset = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 50, 1'b0, 0, 0, 0, 0, 0};
        tbl[1] = '{1'b0,  6, 1'b1, 1, 1, 0, 0, 0};
        tbl[2] = '{1'b1,  6, 1'b0, 1, 0, 1, 0, 0};
        tbl[3] = '{1'b0, 40, 1'b1, 2, 1, 0, 1, 3};
        tbl[4] = '{1'b1,  6, 1'b0, 2, 0, 1, 0, 0};
        tbl[5] = '{1'b0, 12, 1'b1, 3, 1, 0, 0, 0};
        tbl[6] = '{1'b1,  6, 1'b0, 3, 0, 1, 0, 0};
        tbl[7] = '{1'b0, 13, 1'b1, 4, 1, 0, 0, 0};
        tbl[8] = '{1'b1,  6, 1'b0, 4, 0, 1, 1, 0};

        reset = 1'b0;
        dekey = 1'b1;
        model_reset();
        clear_counts();
        #1;
        check("reset_press", int'(press_pulse), 0);
        check("reset_release", int'(release_pulse), 0);
        check("reset_held", int'(held), 0);
        check("reset_count", int'(press_count), 0);
        step();
        step();
        reset = 1'b1;

        // Directed segments with hand-computed event counts.
        for (int i = 0; i < 9; i++) begin
            dekey = tbl[i].dk;
            clear_counts();
            repeat (tbl[i].cyc) step();
            check($sformatf("seg%0d_held", i), int'(held), int'(tbl[i].held));
            check($sformatf("seg%0d_count", i), int'(press_count), tbl[i].cnt);
            check($sformatf("seg%0d_npress", i), n_press, tbl[i].np);
            check($sformatf("seg%0d_nrelease", i), n_rel, tbl[i].nr);
            check($sformatf("seg%0d_nlong", i), n_long, tbl[i].nl);
            check($sformatf("seg%0d_nrepeat", i), n_rep, tbl[i].nrp);
        end

        // 257 short presses wrap the counter to 1.
        reset_pulse();
        clear_counts();
        for (int i = 0; i < 257; i++) begin
            dekey = 1'b0;
            repeat (4) step();
            dekey = 1'b1;
            repeat (4) step();
        end
        check("wrap_npress", n_press, 257);
        check("wrap_nrelease", n_rel, 257);
        check("wrap_count", int'(press_count), 1);

        // Reset while in long-press with the key still down.
        reset_pulse();
        dekey = 1'b0;
        clear_counts();
        repeat (20) step();
        check("long_before_reset", n_long, 1);
        check("held_before_reset", int'(held), 1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("midreset_held", int'(held), 0);
        check("midreset_count", int'(press_count), 0);
        clear_counts();
        step();
        step();
        reset = 1'b1;
        step();
        step();
        check("rerelease_early_press", n_press, 0);
        step();
        check("repress_third_edge", int'(press_pulse), 1);
        check("repress_count", int'(press_count), 1);
        check("midreset_no_release", n_rel, 0);

        // Randomized key activity with occasional asynchronous resets.
        for (int r = 0; r < 150; r++) begin
            if ($urandom_range(0, 19) == 0) reset_pulse();
            dekey = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 30)) step();
        end

        dekey = 1'b1;
        repeat (6) step();
        check("final_idle", int'(held), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
